// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the dual-dataflow processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OS_ACC = 2'd1,
    WS_RUN = 2'd2,
    DRAIN  = 2'd3
  } pe_state_e;

  typedef enum logic {
    MODE_OS = 1'b0,
    MODE_WS = 1'b1
  } pe_mode_e;

  // Clamp bounds for the default 32-bit accumulator; pe_mac_sat derives
  // its own bounds from its ACC parameter.
  localparam int unsigned PE_ACC_DEF = 32;
  localparam logic signed [PE_ACC_DEF-1:0] PE_ACC_MAX = {1'b0, {(PE_ACC_DEF-1){1'b1}}};
  localparam logic signed [PE_ACC_DEF-1:0] PE_ACC_MIN = {1'b1, {(PE_ACC_DEF-1){1'b0}}};

endpackage

// File: rtl/pe_mac_sat.sv
// pe_mac_sat: combinational signed a*b + addend at ACC width.
// PE_SAT_EN defined  -> result clamps to the ACC range, o_ovf flags a clamp.
// PE_SAT_EN undefined -> two's-complement wrap, o_ovf is constant 0.
module pe_mac_sat #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC   = 32
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic signed [ACC-1:0]   i_addend,
  output logic signed [ACC-1:0]   o_sum,
  output logic                    o_ovf
);

  logic signed [2*WIDTH-1:0] w_prod;

`ifdef PE_SAT_EN
  localparam logic signed [ACC-1:0] L_MAX = {1'b0, {(ACC-1){1'b1}}};
  localparam logic signed [ACC-1:0] L_MIN = {1'b1, {(ACC-1){1'b0}}};

  logic signed [ACC:0] w_wide;

  // One extra bit of headroom; top two bits disagreeing means overflow.
  always_comb begin
    w_prod = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    w_wide = (ACC+1)'(w_prod) + (ACC+1)'(i_addend);
    o_ovf  = w_wide[ACC] ^ w_wide[ACC-1];
    if (o_ovf) o_sum = w_wide[ACC] ? L_MIN : L_MAX;
    else       o_sum = w_wide[ACC-1:0];
  end
`else
  // Plain wrap-around sum.
  always_comb begin
    w_prod = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    o_sum  = ACC'(w_prod) + i_addend;
    o_ovf  = 1'b0;
  end
`endif

endmodule

// File: rtl/pe_dual.sv
// pe_dual: systolic-array PE supporting output-stationary (OS) and
// weight-stationary (WS) dataflows with a registered partial-sum chain.
// Optional clamping arithmetic: define PE_SAT_EN.
module pe_dual
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cmd_start,
  input  logic                    mode_in,
  input  logic                    cmd_drain,
  input  logic                    cmd_stop,
  input  logic                    w_load,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic                    a_vld_in,
  input  logic signed [WIDTH-1:0] b_in,
  input  logic                    b_vld_in,
  input  logic signed [ACC-1:0]   psum_in,
  input  logic                    psum_vld_in,
  output logic signed [WIDTH-1:0] a_out,
  output logic                    a_vld_out,
  output logic signed [WIDTH-1:0] b_out,
  output logic                    b_vld_out,
  output logic signed [ACC-1:0]   psum_out,
  output logic                    psum_vld_out,
  output logic signed [ACC-1:0]   acc_out,
  output logic                    busy,
  output logic                    sat_flag
);

  pe_state_e               r_state, w_next;
  pe_mode_e                r_mode;
  logic                    r_drn_first;
  logic signed [ACC-1:0]   r_acc, r_psum;
  logic signed [WIDTH-1:0] r_w, r_a, r_b;
  logic                    r_a_vld, r_b_vld, r_psum_vld, r_sat;

  logic signed [WIDTH-1:0] w_mac_b;
  logic signed [ACC-1:0]   w_mac_add, w_sum;
  logic                    w_ovf, w_acc_en, w_start;

  // Next-state decode; stop beats start beats drain.
  always_comb begin
    w_next = r_state;
    if (cmd_stop)
      w_next = IDLE;
    else if (cmd_start)
      w_next = mode_in ? WS_RUN : OS_ACC;
    else if (cmd_drain && r_state == OS_ACC && r_mode == MODE_OS)
      w_next = DRAIN;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_state <= IDLE;
    else if (en) r_state <= w_next;
  end

  // Single MAC shared by both dataflows: OS adds to the accumulator with
  // b_in, every other state uses the stationary weight and the chain input.
  always_comb begin
    w_mac_b   = (r_state == OS_ACC) ? b_in  : r_w;
    w_mac_add = (r_state == OS_ACC) ? r_acc : psum_in;
    w_start   = cmd_start & ~cmd_stop;
    w_acc_en  = (r_state == OS_ACC) & ~cmd_stop & ~cmd_start & a_vld_in & b_vld_in;
  end

  pe_mac_sat #(.WIDTH(WIDTH), .ACC(ACC)) u_mac (
    .i_a      (a_in),
    .i_b      (w_mac_b),
    .i_addend (w_mac_add),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  // Datapath: pass-through, weight, accumulator, chain output, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_OS;
      r_drn_first <= 1'b0;
      r_acc       <= '0;
      r_psum      <= '0;
      r_psum_vld  <= 1'b0;
      r_w         <= '0;
      r_a         <= '0;
      r_a_vld     <= 1'b0;
      r_b         <= '0;
      r_b_vld     <= 1'b0;
      r_sat       <= 1'b0;
    end else if (en) begin
      r_a     <= a_in;
      r_a_vld <= a_vld_in;
      r_b     <= b_in;
      r_b_vld <= b_vld_in;
      if (w_load) r_w <= b_in;

      unique case (r_state)
        DRAIN: begin
          if (r_drn_first) begin
            r_psum     <= r_acc;
            r_psum_vld <= 1'b1;
          end else begin
            r_psum     <= psum_in;
            r_psum_vld <= psum_vld_in;
          end
        end
        WS_RUN: begin
          r_psum     <= w_sum;
          r_psum_vld <= a_vld_in & psum_vld_in;
        end
        default: begin
          r_psum     <= '0;
          r_psum_vld <= 1'b0;
        end
      endcase

      r_drn_first <= (w_next == DRAIN) && (r_state != DRAIN);

      if (w_start) begin
        r_mode <= pe_mode_e'(mode_in);
        if (!mode_in) r_acc <= '0;
      end else if (w_acc_en) begin
        r_acc <= w_sum;
      end

      if (w_start)
        r_sat <= 1'b0;
      else if ((w_acc_en || r_state == WS_RUN) && w_ovf)
        r_sat <= 1'b1;
    end
  end

  assign a_out        = r_a;
  assign a_vld_out    = r_a_vld;
  assign b_out        = r_b;
  assign b_vld_out    = r_b_vld;
  assign psum_out     = r_psum;
  assign psum_vld_out = r_psum_vld;
  assign acc_out      = r_acc;
  assign busy         = (r_state != IDLE);
  assign sat_flag     = r_sat;

endmodule

// File: tb/tb_pe_dual.sv
// tb_pe_dual: randomized + directed self-checking bench for pe_dual.
// u_dut (8/32) is tracked cycle-by-cycle by a behavioural model; a 3-PE
// column (8/16) covers chained drain and saturation/wrap behaviour.
module tb_pe_dual;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, cmd_start, mode_in, cmd_drain, cmd_stop, w_load;
  logic signed [7:0]  a_in, b_in, a_out, b_out;
  logic a_vld_in, b_vld_in, psum_vld_in, a_vld_out, b_vld_out, psum_vld_out;
  logic signed [31:0] psum_in, psum_out, acc_out;
  logic busy, sat_flag;

  pe_dual #(.WIDTH(8), .ACC(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cmd_start(cmd_start), .mode_in(mode_in),
    .cmd_drain(cmd_drain), .cmd_stop(cmd_stop), .w_load(w_load),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .psum_in(psum_in), .psum_vld_in(psum_vld_in),
    .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
    .psum_out(psum_out), .psum_vld_out(psum_vld_out), .acc_out(acc_out),
    .busy(busy), .sat_flag(sat_flag)
  );

  // Three-PE column, psum chained top to bottom, top chain input tied 0/1.
  logic c_start, c_mode, c_drain, c_stop;
  logic signed [7:0]  ca [3], cb [3], cao [3], cbo [3];
  logic               cav [3], cbv [3], caov [3], cbov [3];
  logic signed [15:0] c_pin [3], c_pout [3], c_acc [3];
  logic               c_pvin [3], c_pvout [3], c_busy [3], c_sat [3];

  assign c_pin[0]  = '0;
  assign c_pvin[0] = 1'b1;

  for (genvar g = 0; g < 3; g++) begin : g_col
    if (g > 0) begin : g_link
      assign c_pin[g]  = c_pout[g-1];
      assign c_pvin[g] = c_pvout[g-1];
    end
    pe_dual #(.WIDTH(8), .ACC(16)) u_pe (
      .clk(clk), .rst(rst), .en(en), .cmd_start(c_start), .mode_in(c_mode),
      .cmd_drain(c_drain), .cmd_stop(c_stop), .w_load(1'b0),
      .a_in(ca[g]), .a_vld_in(cav[g]), .b_in(cb[g]), .b_vld_in(cbv[g]),
      .psum_in(c_pin[g]), .psum_vld_in(c_pvin[g]),
      .a_out(cao[g]), .a_vld_out(caov[g]), .b_out(cbo[g]), .b_vld_out(cbov[g]),
      .psum_out(c_pout[g]), .psum_vld_out(c_pvout[g]), .acc_out(c_acc[g]),
      .busy(c_busy[g]), .sat_flag(c_sat[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of u_dut ----------------
  // m_state: 0 idle, 1 OS accumulate, 2 WS run, 3 drain
  int     m_state;
  bit     m_first, m_sat;
  longint m_acc, m_w;
  longint e_a, e_b, e_psum;
  bit     e_av, e_bv, e_pv;

  task automatic model_reset();
    m_state = 0; m_first = 0; m_sat = 0; m_acc = 0; m_w = 0;
    e_a = 0; e_b = 0; e_psum = 0; e_av = 0; e_bv = 0; e_pv = 0;
  endtask

  // Bring an ideal sum into the 32-bit accumulator range.
  task automatic fix32(input longint x, output longint r, output bit cl);
`ifdef PE_SAT_EN
    cl = 1'b1;
    if (x > 64'sd2147483647)       r = 64'sd2147483647;
    else if (x < -64'sd2147483648) r = -64'sd2147483648;
    else begin r = x; cl = 1'b0; end
`else
    r  = longint'(int'(x));
    cl = 1'b0;
`endif
  endtask

  task automatic model_step();
    longint r;
    bit cl, nf;
    if (!en) return;
    case (m_state)
      3: if (m_first) begin e_psum = m_acc; e_pv = 1; end
         else begin e_psum = longint'(psum_in); e_pv = psum_vld_in; end
      2: begin
        fix32(longint'(psum_in) + longint'(a_in) * m_w, r, cl);
        e_psum = r; e_pv = a_vld_in & psum_vld_in;
        if (cl) m_sat = 1;
      end
      default: begin e_psum = 0; e_pv = 0; end
    endcase
    if (m_state == 1 && !cmd_stop && !cmd_start && a_vld_in && b_vld_in) begin
      fix32(m_acc + longint'(a_in) * longint'(b_in), r, cl);
      m_acc = r;
      if (cl) m_sat = 1;
    end
    if (w_load) m_w = longint'(b_in);
    e_a = longint'(a_in); e_av = a_vld_in;
    e_b = longint'(b_in); e_bv = b_vld_in;
    nf = 0;
    if (cmd_stop) m_state = 0;
    else if (cmd_start) begin
      m_sat = 0;
      if (!mode_in) begin m_acc = 0; m_state = 1; end
      else m_state = 2;
    end else if (cmd_drain && m_state == 1) begin
      m_state = 3; nf = 1;
    end
    m_first = nf;
  endtask

  task automatic compare();
    check("a_out", longint'(a_out), e_a);
    check("a_vld_out", longint'(a_vld_out), longint'(e_av));
    check("b_out", longint'(b_out), e_b);
    check("b_vld_out", longint'(b_vld_out), longint'(e_bv));
    check("psum_vld_out", longint'(psum_vld_out), longint'(e_pv));
    if (e_pv) check("psum_out", longint'(psum_out), e_psum);
    check("acc_out", longint'(acc_out), m_acc);
    check("busy", longint'(busy), longint'(m_state != 0));
    check("sat_flag", longint'(sat_flag), longint'(m_sat));
  endtask

  // One clock: model follows the edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    cmd_start = 0; mode_in = 0; cmd_drain = 0; cmd_stop = 0; w_load = 0;
    a_in = 0; a_vld_in = 0; b_in = 0; b_vld_in = 0; psum_in = 0; psum_vld_in = 0;
  endtask

  task automatic col_idle();
    c_start = 0; c_mode = 0; c_drain = 0; c_stop = 0;
    for (int i = 0; i < 3; i++) begin ca[i] = 0; cb[i] = 0; cav[i] = 0; cbv[i] = 0; end
  endtask

  task automatic os_pair(input int a, input int b, input bit av, input bit bv);
    a_in = 8'(a); b_in = 8'(b); a_vld_in = av; b_vld_in = bv;
    cyc();
  endtask

  initial begin
    rst = 1; en = 1;
    idle_in(); col_idle(); model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_acc", longint'(acc_out), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_psum_vld", longint'(psum_vld_out), 0);
    compare();
    rst = 0;

    // OS accumulate with an invalid cycle in the middle.
    cmd_start = 1; mode_in = 0; cyc(); idle_in();
    os_pair(3, 4, 1, 1);
    os_pair(9, 9, 1, 0);
    os_pair(-2, 5, 1, 1);
    os_pair(7, 7, 1, 1);
    check("os_acc51", longint'(acc_out), 51);

    // Stall: acc and a_out must hold while inputs change.
    en = 0;
    for (int i = 0; i < 3; i++) begin
      a_in = 8'(i + 20); b_in = 8'(i); a_vld_in = 1; b_vld_in = 1; cyc();
    end
    check("stall_acc", longint'(acc_out), 51);
    check("stall_a_out", longint'(a_out), 7);
    en = 1; idle_in();

    // Single-PE drain: own acc first, then chain input.
    cmd_drain = 1; cyc(); idle_in();
    psum_in = 77; psum_vld_in = 1; cyc();
    check("drain_first", longint'(psum_out), 51);
    cyc();
    check("drain_chain", longint'(psum_out), 77);

    // stop + start together: stop wins.
    cmd_stop = 1; cmd_start = 1; mode_in = 1; cyc(); idle_in();
    check("stop_prio_busy", longint'(busy), 0);

    // WS: load 6, then 100 + 5*6; same-cycle load uses old weight.
    cmd_start = 1; mode_in = 1; cyc(); idle_in();
    w_load = 1; b_in = 6; cyc(); idle_in();
    a_in = 5; a_vld_in = 1; psum_in = 100; psum_vld_in = 1; cyc();
    check("ws_130", longint'(psum_out), 130);
    w_load = 1; b_in = -3; a_in = 2; psum_in = 10; cyc();
    check("ws_old_w", longint'(psum_out), 22);
    w_load = 0; cyc();
    check("ws_new_w", longint'(psum_out), 4);
    idle_in();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en          = ($urandom_range(0, 9) != 0);
      cmd_stop    = ($urandom_range(0, 39) == 0);
      cmd_start   = ($urandom_range(0, 19) == 0);
      mode_in     = 1'($urandom);
      cmd_drain   = ($urandom_range(0, 14) == 0);
      w_load      = ($urandom_range(0, 3) == 0);
      a_in        = 8'($urandom);
      b_in        = 8'($urandom);
      a_vld_in    = ($urandom_range(0, 3) != 0);
      b_vld_in    = ($urandom_range(0, 3) != 0);
      psum_in     = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000));
      psum_vld_in = ($urandom_range(0, 3) != 0);
      cyc();
    end
    en = 1; idle_in();

    // Asynchronous reset mid-OS with acc = 500, checked before the next edge.
    cmd_stop = 1; cyc(); idle_in();
    cmd_start = 1; cyc(); idle_in();
    os_pair(20, 25, 1, 1);
    idle_in();
    check("pre_rst_acc", longint'(acc_out), 500);
    #2 rst = 1;
    #1;
    check("arst_acc", longint'(acc_out), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_a_out", longint'(a_out), 0);
    check("arst_b_out", longint'(b_out), 0);
    check("arst_psum", longint'(psum_out), 0);
    check("arst_vld", longint'(a_vld_out | b_vld_out | psum_vld_out | sat_flag), 0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Column drain: accs 10/20/30, bottom emits 30, 20, 10.
    c_start = 1; c_mode = 0; cyc(); c_start = 0;
    ca[0] = 2; cb[0] = 5; ca[1] = 4; cb[1] = 5; ca[2] = 5; cb[2] = 6;
    for (int i = 0; i < 3; i++) begin cav[i] = 1; cbv[i] = 1; end
    cyc(); col_idle();
    check("col_acc0", longint'(c_acc[0]), 10);
    check("col_acc1", longint'(c_acc[1]), 20);
    check("col_acc2", longint'(c_acc[2]), 30);
    c_drain = 1; cyc(); c_drain = 0;
    check("col_pre_vld", longint'(c_pvout[2]), 0);
    cyc();
    check("col_d1", longint'(c_pout[2]), 30);
    check("col_d1_vld", longint'(c_pvout[2]), 1);
    cyc();
    check("col_d2", longint'(c_pout[2]), 20);
    check("col_d2_vld", longint'(c_pvout[2]), 1);
    cyc();
    check("col_d3", longint'(c_pout[2]), 10);
    check("col_d3_vld", longint'(c_pvout[2]), 1);
    c_stop = 1; cyc(); c_stop = 0;
    check("col_stop_busy", longint'(c_busy[2]), 0);

    // 16-bit accumulator: three 127*127 products overflow.
    c_start = 1; cyc(); c_start = 0;
    ca[0] = 127; cb[0] = 127; cav[0] = 1; cbv[0] = 1;
    for (int i = 0; i < 3; i++) cyc();
    col_idle();
`ifdef PE_SAT_EN
    check("sat_acc", longint'(c_acc[0]), 32767);
    check("sat_flag_set", longint'(c_sat[0]), 1);
`else
    check("wrap_acc", longint'(c_acc[0]), -17149);
    check("wrap_flag", longint'(c_sat[0]), 0);
`endif
    c_start = 1; cyc(); c_start = 0;
    check("sat_cleared", longint'(c_sat[0]), 0);
    check("restart_acc", longint'(c_acc[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
